digit_scan_ctrl: RTL and testbench

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/digit_scan_pkg.sv | 19 +
 rtl/scan_timer.sv | 27 ++
 rtl/digit_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the multiplexed BCD digit scanner.
package digit_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   // Bits needed to hold max(a,b)-1, never less than one.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that stops at zero and flags terminal count.
module scan_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         tc
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed BCD digit scanner with blanking gaps and frame-aligned updates.
// Build option: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module digit_scan_ctrl
   import digit_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BLANK_CYC  = 2,
   parameter int DWELL_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   sel_n,
   output logic                    frame_done,
   output logic                    upd_pend
);

   localparam int TW = timer_width(BLANK_CYC, DWELL_CYC);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYC - 1);
   localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYC - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   state_t                  state, state_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic [4*NUM_DIGITS-1:0] active, pending;
   logic                    tm_clr, tm_load, tm_tc;
   logic [TW-1:0]           tm_val, tm_count;
   logic                    frame_end;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [3:0]              cur_digit;
   logic                    cur_lz;

   scan_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tm_clr),
      .load     (tm_load),
      .load_val (tm_val),
      .count    (tm_count),
      .tc       (tm_tc)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      tm_clr    = 1'b0;
      tm_load   = 1'b0;
      tm_val    = '0;
      if (!en) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         tm_clr    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = BLANK;
               idx_nxt   = '0;
               tm_load   = 1'b1;
               tm_val    = BLANK_LD;
            end
            BLANK: if (tm_tc) begin
               state_nxt = DRIVE;
               tm_load   = 1'b1;
               tm_val    = DWELL_LD;
            end
            DRIVE: if (tm_tc) begin
               state_nxt = BLANK;
               tm_load   = 1'b1;
               tm_val    = BLANK_LD;
               idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            default: begin
               state_nxt = IDLE;
               idx_nxt   = '0;
               tm_clr    = 1'b1;
            end
         endcase
      end
   end

   assign frame_end = (state == DRIVE) && tm_tc && (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // NOTE: the digit registers are reset explicitly so a restart never shows stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         active     <= '0;
         pending    <= '0;
         upd_pend   <= 1'b0;
         frame_done <= 1'b0;
      end else if (!en || state == IDLE) begin
         // Not scanning: there is no frame boundary to wait for.
         frame_done <= 1'b0;
         upd_pend   <= 1'b0;
         if (load) begin
            active <= digits;
         end else if (upd_pend) begin
            active <= pending;
         end
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            if (upd_pend) begin
               active <= pending;
            end
            upd_pend <= load;
         end else if (load) begin
            upd_pend <= 1'b1;
         end
         if (load) begin
            pending <= digits;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic hz;
      hz      = 1'b1;
      lz_mask = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         hz         = hz & (active[4*k +: 4] == 4'd0);
         lz_mask[k] = hz;
      end
   end
`else
   assign lz_mask = '0;
`endif

   always_comb begin
      cur_digit = '0;
      cur_lz    = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_digit = active[4*k +: 4];
            cur_lz    = lz_mask[k];
         end
      end
      sel_n   = '1;
      bcd_out = BCD_BLANK;
      case (state)
         BLANK: bcd_out = cur_digit;
         DRIVE: begin
            if (!cur_lz) begin
               bcd_out = cur_digit;
               for (int k = 0; k < NUM_DIGITS; k++) begin
                  sel_n[k] = (idx != IW'(k));
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl (4 digits, 2 blank + 4 dwell cycles).
module tb_digit_scan_ctrl;

   localparam int N = 4;
   localparam int B = 2;
   localparam int D = 4;

   typedef struct packed {
      logic [3:0] sel_n;
      logic [3:0] bcd;
      logic       fd;
      logic       up;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          en;
   logic          load;
   logic [15:0]   digits;
   logic [3:0]    bcd_out;
   logic [N-1:0]  sel_n;
   logic          frame_done;
   logic          upd_pend;

   exp_t          exp_q[$];
   int            checks;
   int            errors;
   int            cyc;
   string         cur_test;

   // Spec-level model of the displayed registers.
   logic [15:0]   m_active;
   logic [15:0]   m_pending;
   logic          m_up;
   logic          m_fd;

   digit_scan_ctrl #(
      .NUM_DIGITS (N),
      .BLANK_CYC  (B),
      .DWELL_CYC  (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .digits     (digits),
      .bcd_out    (bcd_out),
      .sel_n      (sel_n),
      .frame_done (frame_done),
      .upd_pend   (upd_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic lz_blank(input int k, input logic [15:0] a);
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 0) return 1'b0;
      for (int j = k; j < N; j++) begin
         if (a[4*j +: 4] != 4'd0) return 1'b0;
      end
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic push(input logic [3:0] s, input logic [3:0] b, input logic fd, input logic up);
      exp_t e;
      e.sel_n = s;
      e.bcd   = b;
      e.fd    = fd;
      e.up    = up;
      exp_q.push_back(e);
   endtask

   // Consume one scoreboard entry at the falling edge, then step past the next rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s cyc %0d: scoreboard empty, got sel_n=%b bcd=%h", cur_test, cyc, sel_n, bcd_out);
      end else begin
         e = exp_q.pop_front();
         if (sel_n !== e.sel_n || bcd_out !== e.bcd || frame_done !== e.fd || upd_pend !== e.up) begin
            errors++;
            $display("FAIL %s cyc %0d: got sel_n=%b bcd=%h fd=%b up=%b, want sel_n=%b bcd=%h fd=%b up=%b",
                     cur_test, cyc, sel_n, bcd_out, frame_done, upd_pend,
                     e.sel_n, e.bcd, e.fd, e.up);
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run_slot(input int k, input int ld_pos, input logic [15:0] ld_val,
                           input int abort_at, input bit abort_rst);
      logic [3:0] v;
      bit         ld;
      v = m_active[4*k +: 4];
      for (int c = 0; c < B + D; c++) begin
         if (c < B)                    push(4'b1111, v, m_fd, m_up);
         else if (lz_blank(k, m_active)) push(4'b1111, 4'hF, 1'b0, m_up);
         else                          push(~(4'b0001 << k), v, 1'b0, m_up);
         ld     = (ld_pos == 1 && c == 0) || (ld_pos == 2 && c == B + D - 1);
         load   = ld;
         digits = ld ? ld_val : digits;
         if (c == abort_at) begin
            if (abort_rst) rst = 1'b1;
            else           en  = 1'b0;
         end
         tick();
         load = 1'b0;
         m_fd = 1'b0;
         if (c == abort_at) begin
            if (abort_rst) begin
               m_active  = '0;
               m_pending = '0;
            end else if (m_up) begin
               m_active = m_pending;
            end
            m_up = 1'b0;
            return;
         end
         if (k == N - 1 && c == B + D - 1) begin
            m_fd = 1'b1;
            if (m_up) m_active = m_pending;
            m_up = 1'b0;
         end
         if (ld) begin
            m_pending = ld_val;
            m_up      = 1'b1;
         end
      end
   endtask

   task automatic frame();
      for (int k = 0; k < N; k++) run_slot(k, 0, 16'h0, -1, 1'b0);
   endtask

   task automatic start_scan();
      en = 1'b1;
      push(4'b1111, 4'hF, 1'b0, 1'b0);
      tick();
      m_fd = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         push(4'b1111, 4'hF, 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic idle_load(input logic [15:0] v);
      push(4'b1111, 4'hF, 1'b0, 1'b0);
      load   = 1'b1;
      digits = v;
      tick();
      load     = 1'b0;
      m_active = v;
   endtask

   task automatic test_reset();
      cur_test = "reset";
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sel_n !== 4'b1111) begin errors++; $display("FAIL reset_sel_n: got %b want 1111", sel_n); end
      checks++;
      if (bcd_out !== 4'hF) begin errors++; $display("FAIL reset_bcd: got %h want f", bcd_out); end
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      checks++;
      if (upd_pend !== 1'b0) begin errors++; $display("FAIL reset_upd_pend: got %b want 0", upd_pend); end
      rst = 1'b0;
      idle_load(16'h1234);
      idle_cycles(2);
   endtask

   task automatic test_scan_order();
      cur_test = "scan_order";
      start_scan();
      frame();
      frame();
   endtask

   task automatic test_deferred();
      cur_test = "deferred";
      run_slot(0, 1, 16'h4321, -1, 1'b0);
      run_slot(1, 1, 16'h5678, -1, 1'b0);
      run_slot(2, 0, 16'h0, -1, 1'b0);
      run_slot(3, 0, 16'h0, -1, 1'b0);
      frame();
   endtask

   task automatic test_boundary_load();
      cur_test = "boundary_load";
      run_slot(0, 1, 16'h9C21, -1, 1'b0);
      run_slot(1, 0, 16'h0, -1, 1'b0);
      run_slot(2, 0, 16'h0, -1, 1'b0);
      run_slot(3, 2, 16'h3A0B, -1, 1'b0);
      frame();
      frame();
   endtask

   task automatic test_disable();
      cur_test = "disable";
      run_slot(0, 0, 16'h0, -1, 1'b0);
      run_slot(1, 0, 16'h0, B + 1, 1'b0);
      idle_cycles(2);
      start_scan();
      frame();
      for (int k = 0; k < N - 1; k++) run_slot(k, 0, 16'h0, -1, 1'b0);
      run_slot(N - 1, 0, 16'h0, B + D - 1, 1'b0);
      idle_cycles(2);
   endtask

   task automatic test_leading_zero();
      cur_test = "leading_zero";
      idle_load(16'h0070);
      idle_cycles(1);
      start_scan();
      frame();
   endtask

   task automatic test_reset_mid_drive();
      cur_test = "reset_mid_drive";
      run_slot(0, 1, 16'h1111, -1, 1'b0);
      run_slot(1, 0, 16'h0, -1, 1'b0);
      run_slot(2, 0, 16'h0, B + 1, 1'b1);
      checks++;
      if (sel_n !== 4'b1111) begin errors++; $display("FAIL rst_mid_sel_n: got %b want 1111", sel_n); end
      checks++;
      if (bcd_out !== 4'hF) begin errors++; $display("FAIL rst_mid_bcd: got %h want f", bcd_out); end
      checks++;
      if (upd_pend !== 1'b0) begin errors++; $display("FAIL rst_mid_upd_pend: got %b want 0", upd_pend); end
      // Reset must win over a simultaneous enable and load.
      push(4'b1111, 4'hF, 1'b0, 1'b0);
      load   = 1'b1;
      digits = 16'h9999;
      tick();
      load = 1'b0;
      rst  = 1'b0;
      push(4'b1111, 4'hF, 1'b0, 1'b0);
      tick();
      m_fd = 1'b0;
      frame();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      rst       = 1'b1;
      en        = 1'b0;
      load      = 1'b0;
      digits    = '0;
      m_active  = '0;
      m_pending = '0;
      m_up      = 1'b0;
      m_fd      = 1'b0;

      test_reset();
      test_scan_order();
      test_deferred();
      test_boundary_load();
      test_disable();
      test_leading_zero();
      test_reset_mid_drive();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
